// File: rtl/csc_rgb_writer.sv
// csc_rgb_writer: converts one even/odd Y/U'/V' pixel pair to RGB using two
// time-shared multipliers, clips each channel to 8 bits, packs the pair into
// three 16-bit words and writes them through the SRAM arbiter.
// Optional build macro: CSC_ROUND_EN (round-half-up before the >>>16 shift).
module csc_rgb_writer #(
   parameter logic [17:0] RGB_BASE        = 18'd146944,
   parameter int          PAIRS_PER_FRAME = 38400
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  Y0,
   input  logic [7:0]  Y1,
   input  logic [7:0]  U0,
   input  logic [7:0]  U1,
   input  logic [7:0]  V0,
   input  logic [7:0]  V1,
   input  logic        wr_grant,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        Busy,
   output logic        Done
);

   localparam int              CNT_W     = $clog2(PAIRS_PER_FRAME + 1);
   localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS_PER_FRAME - 1);

   typedef enum logic [3:0] {
      S_FIDLE,
      S_ACCEPT,
      S_M0,
      S_M1,
      S_M2,
      S_M3,
      S_M4,
      S_W0,
      S_W1,
      S_W2
   } state_t;

   state_t state, state_next;

   logic signed [9:0]  y0, y1, u0, u1, v0, v1;
   logic signed [31:0] r0, g0, b0, r1, g1, b1;
   logic signed [31:0] op_a0, op_b0, op_a1, op_b1;
   logic signed [31:0] prod0, prod1;
   logic [CNT_W-1:0]   pair_count;
   logic [7:0]         r0_pix, g0_pix, b0_pix, r1_pix, g1_pix, b1_pix;
   logic               write_fire;

   // Scale an accumulator back to pixel range and saturate to 0..255.
   function automatic logic [7:0] clip(input logic signed [31:0] acc);
      logic signed [31:0] s;
`ifdef CSC_ROUND_EN
      s = (acc + 32'sd32768) >>> 16;
`else
      s = acc >>> 16;
`endif
      if (s < 32'sd0)
         clip = 8'd0;
      else if (s > 32'sd255)
         clip = 8'd255;
      else
         clip = s[7:0];
   endfunction

   assign r0_pix = clip(r0);
   assign g0_pix = clip(g0);
   assign b0_pix = clip(b0);
   assign r1_pix = clip(r1);
   assign g1_pix = clip(g1);
   assign b1_pix = clip(b1);

   assign write_fire = wr_grant && (state inside {S_W0, S_W1, S_W2});

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset)
         state <= S_FIDLE;
      else
         state <= state_next;
   end

   // Next-state logic plus the handshake and SRAM write-port outputs.
   always_comb begin
      state_next      = state;
      in_ready        = 1'b0;
      SRAM_we_n       = 1'b1;
      SRAM_write_data = '0;
      case (state)
         S_FIDLE: begin
            if (Start)
               state_next = S_ACCEPT;
         end
         S_ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid)
               state_next = S_M0;
         end
         S_M0: state_next = S_M1;
         S_M1: state_next = S_M2;
         S_M2: state_next = S_M3;
         S_M3: state_next = S_M4;
         S_M4: state_next = S_W0;
         S_W0: begin
            SRAM_write_data = {r0_pix, g0_pix};
            SRAM_we_n       = ~wr_grant;
            if (wr_grant)
               state_next = S_W1;
         end
         S_W1: begin
            SRAM_write_data = {b0_pix, r1_pix};
            SRAM_we_n       = ~wr_grant;
            if (wr_grant)
               state_next = S_W2;
         end
         S_W2: begin
            SRAM_write_data = {g1_pix, b1_pix};
            SRAM_we_n       = ~wr_grant;
            if (wr_grant)
               state_next = (pair_count == LAST_PAIR) ? S_FIDLE : S_ACCEPT;
         end
         default: state_next = S_FIDLE;
      endcase
   end

   // Operand selection for the two shared multipliers, one schedule slot per M state.
   always_comb begin
      op_a0 = '0;
      op_b0 = '0;
      op_a1 = '0;
      op_b1 = '0;
      case (state)
         S_M0: begin
            op_a0 = 32'(y0); op_b0 = 32'sd76284;
            op_a1 = 32'(v0); op_b1 = 32'sd104595;
         end
         S_M1: begin
            op_a0 = 32'(u0); op_b0 = 32'sd25624;
            op_a1 = 32'(v0); op_b1 = 32'sd53281;
         end
         S_M2: begin
            op_a0 = 32'(u0); op_b0 = 32'sd132251;
            op_a1 = 32'(y1); op_b1 = 32'sd76284;
         end
         S_M3: begin
            op_a0 = 32'(v1); op_b0 = 32'sd104595;
            op_a1 = 32'(u1); op_b1 = 32'sd25624;
         end
         S_M4: begin
            op_a0 = 32'(v1); op_b0 = 32'sd53281;
            op_a1 = 32'(u1); op_b1 = 32'sd132251;
         end
         default: begin
            op_a0 = '0;
         end
      endcase
   end

   assign prod0 = op_a0 * op_b0;
   assign prod1 = op_a1 * op_b1;

   // Capture the offset inputs on accept and accumulate products into the six channels.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         y0 <= '0; y1 <= '0; u0 <= '0; u1 <= '0; v0 <= '0; v1 <= '0;
         r0 <= '0; g0 <= '0; b0 <= '0; r1 <= '0; g1 <= '0; b1 <= '0;
      end else begin
         case (state)
            S_ACCEPT: begin
               if (in_valid) begin
                  y0 <= $signed({2'b00, Y0}) - 10'sd16;
                  y1 <= $signed({2'b00, Y1}) - 10'sd16;
                  u0 <= $signed({2'b00, U0}) - 10'sd128;
                  u1 <= $signed({2'b00, U1}) - 10'sd128;
                  v0 <= $signed({2'b00, V0}) - 10'sd128;
                  v1 <= $signed({2'b00, V1}) - 10'sd128;
                  r0 <= '0; g0 <= '0; b0 <= '0;
                  r1 <= '0; g1 <= '0; b1 <= '0;
               end
            end
            S_M0: begin
               r0 <= r0 + prod0 + prod1;
               g0 <= g0 + prod0;
               b0 <= b0 + prod0;
            end
            S_M1: begin
               g0 <= g0 - prod0 - prod1;
            end
            S_M2: begin
               b0 <= b0 + prod0;
               r1 <= r1 + prod1;
               g1 <= g1 + prod1;
               b1 <= b1 + prod1;
            end
            S_M3: begin
               r1 <= r1 + prod0;
               g1 <= g1 - prod1;
            end
            S_M4: begin
               g1 <= g1 - prod0;
               b1 <= b1 + prod1;
            end
            default: begin
               r0 <= r0;
            end
         endcase
      end
   end

   // Frame bookkeeping: write address, pair counter, Busy and the Done pulse.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         SRAM_address <= RGB_BASE;
         pair_count   <= '0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (state == S_FIDLE && Start) begin
            Busy         <= 1'b1;
            SRAM_address <= RGB_BASE;
            pair_count   <= '0;
         end
         if (write_fire)
            SRAM_address <= SRAM_address + 18'd1;
         if (state == S_W2 && wr_grant) begin
            pair_count <= pair_count + CNT_W'(1);
            if (pair_count == LAST_PAIR) begin
               Done <= 1'b1;
               Busy <= 1'b0;
            end
         end
      end
   end

endmodule
